// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding and the buffered command payload.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

package apb_master_pkg;

    localparam int AW = `ADDRWIDTH;
    localparam int DW = `DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB pins of the requester, bundled for port connection.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int ADDRWIDTH = AW,
    parameter int DATAWIDTH = DW
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_wdata;

    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic                 rsp_timeout;
    logic                 busy;

    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_cmd_buf.sv
// One-entry command holding register; ready is purely the registered empty flag.
module apb_cmd_buf
    import apb_master_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  apb_cmd_t in_cmd,
    output logic     in_ready,
    input  logic     pop,
    output logic     full,
    output apb_cmd_t cmd
);

    assign in_ready = ~full;

    // Accept and pop never coincide: accept needs the buffer empty, pop needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            cmd  <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            cmd  <= in_cmd;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: buffered valid/ready commands become SETUP/ACCESS transfers with an
// optional wait-state timeout; one response pulse per transfer.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDRWIDTH = `ADDRWIDTH,
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int TIMEOUT   = 16
) (
    input logic          PCLK,
    input logic          PRESETn,
    apb_master_if.master bus
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_e           state, state_nxt;
    apb_cmd_t             req_cmd, buf_cmd;
    logic                 buf_full, buf_ready;
    logic                 load, done, tmo;
    logic [CW-1:0]        cnt;
    logic                 pwrite_q;
    logic [ADDRWIDTH-1:0] paddr_q;
    logic [DATAWIDTH-1:0] pwdata_q;
    logic                 rsp_valid_q, rsp_timeout_q;
    logic [DATAWIDTH-1:0] rsp_rdata_q;
    logic                 psel, penable, busy;

    assign req_cmd = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    apb_cmd_buf u_buf (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .in_valid (bus.req_valid),
        .in_cmd   (req_cmd),
        .in_ready (buf_ready),
        .pop      (load),
        .full     (buf_full),
        .cmd      (buf_cmd)
    );

    // Abort on the edge where the PREADY-low count would reach TIMEOUT.
    assign tmo  = (TIMEOUT != 0) && (state == ACCESS) && !bus.PREADY &&
                  ((32'(cnt) + 32'd1) == 32'(TIMEOUT));
    assign done = (state == ACCESS) && (bus.PREADY || tmo);
    assign load = buf_full && ((state == IDLE) || done);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_full) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = buf_full ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        case (state)
            SETUP:  psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
        busy = (state != IDLE) || buf_full;
    end

    // Address/data only move on a load, so they hold through IDLE and wait states.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (load) begin
            pwrite_q <= buf_cmd.write;
            paddr_q  <= buf_cmd.addr;
            pwdata_q <= buf_cmd.wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                         cnt <= '0;
        else if (state == SETUP)              cnt <= '0;
        else if (state == ACCESS && !bus.PREADY) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            rsp_valid_q   <= done;
            rsp_timeout_q <= tmo;
            rsp_rdata_q   <= (done && bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
        end
    end

    assign bus.req_ready   = buf_ready;
    assign bus.busy        = busy;
    assign bus.PSEL        = psel;
    assign bus.PENABLE     = penable;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: randomized commands against a memory model and an APB completer.
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int TMO   = 4;
    localparam int STUCK = 1000;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    apb_master_if bus ();

    apb_master #(.TIMEOUT(TMO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          tmo;
        int            en;
    } exp_t;

    exp_t          exp_q[$];
    int            waits_q[$];
    logic [DW-1:0] model_mem [64];
    logic [DW-1:0] slv_mem   [64];
    int passed = 0, total = 0, cyc = 0;
    int cur_waits = 0, acc_cyc = 0, en_cnt = 0;
    exp_t          me;
    logic          s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Completer: wait count per transfer comes from the stimulus, latched at SETUP.
    assign bus.PREADY = (acc_cyc >= cur_waits);

    always @(posedge PCLK) begin
        if (bus.PSEL && !bus.PENABLE) begin
            acc_cyc    <= 0;
            cur_waits  <= (waits_q.size() > 0) ? waits_q.pop_front() : 0;
            bus.PRDATA <= slv_mem[bus.PADDR[7:2]];
        end else if (bus.PSEL && bus.PENABLE) begin
            if (bus.PREADY) begin
                if (bus.PWRITE) slv_mem[bus.PADDR[7:2]] <= bus.PWDATA;
            end else begin
                acc_cyc <= acc_cyc + 1;
            end
        end
    end

    // Monitor: response pops the scoreboard; SETUP/ACCESS checked against the head entry.
    always @(negedge PCLK) begin
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) fail("stray_rsp");
            else begin
                me = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, me.rdata);
                chk("rsp_timeout", bus.rsp_timeout, me.tmo);
                chk("penable_cycles", en_cnt, me.en);
            end
            en_cnt = 0;
        end
        if (bus.PSEL && !bus.PENABLE) begin
            if (exp_q.size() == 0) fail("stray_setup");
            else begin
                chk("setup_paddr", bus.PADDR, exp_q[0].addr);
                chk("setup_pwrite", bus.PWRITE, exp_q[0].write);
                if (exp_q[0].write) chk("setup_pwdata", bus.PWDATA, exp_q[0].wdata);
            end
            s_write = bus.PWRITE;
            s_addr  = bus.PADDR;
            s_wdata = bus.PWDATA;
        end
        if (bus.PSEL && bus.PENABLE) begin
            en_cnt++;
            chk("access_stable", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {s_write, s_addr, s_wdata});
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, output int acc);
        exp_t e;
        int   n = 0;
        acc = -1;
        @(negedge PCLK);
        while (!bus.req_ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 200) begin
            fail("req_ready_wait");
            return;
        end
        e.write = w;
        e.addr  = a;
        e.wdata = d;
        e.tmo   = (waits >= TMO);
        e.en    = e.tmo ? TMO : waits + 1;
        e.rdata = (w || e.tmo) ? '0 : model_mem[a[7:2]];
        if (w && !e.tmo) model_mem[a[7:2]] = d;
        exp_q.push_back(e);
        waits_q.push_back(waits);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge PCLK);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        int n = 0;
        c = -1;
        do begin
            @(negedge PCLK);
            n++;
        end while (!bus.rsp_valid && n < 100);
        if (!bus.rsp_valid) fail("rsp_wait");
        else c = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge PCLK);
            n++;
        end
        if (exp_q.size() != 0) fail("drain");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_psel_penable"}, {bus.PSEL, bus.PENABLE}, 2'b00);
        chk({tag, "_pwrite_paddr_pwdata"}, {bus.PWRITE, bus.PADDR, bus.PWDATA}, '0);
        chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}, '0);
        chk({tag, "_busy_ready"}, {bus.busy, bus.req_ready}, 2'b01);
    endtask

    initial begin
        int a0, a1, c0, c1, highs;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = '0;
            slv_mem[i]   = '0;
        end

        #23;
        chk_reset_vals("in_reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk_reset_vals("after_reset");

        // Zero-wait write: response three edges after accept.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 0, a0);
        wait_rsp(c0);
        chk("write_latency", c0 - a0, 3);
        drain();

        issue(1'b0, 32'h10, '0, 0, a0);
        drain();

        // Three wait states.
        issue(1'b1, 32'h20, 32'h12345678, 3, a0);
        drain();

        // Read queued while the write is in SETUP: no IDLE between transfers.
        issue(1'b1, 32'h04, 32'hCAFE0004, 0, a0);
        issue(1'b0, 32'h04, '0, 0, a1);
        wait_rsp(c0);
        wait_rsp(c1);
        chk("b2b_rsp_spacing", c1 - c0, 2);
        drain();

        // Stuck completer aborts after TMO edges; PSEL already low in the response cycle.
        issue(1'b1, 32'h30, 32'h0BADF00D, STUCK, a0);
        wait_rsp(c0);
        chk("tmo_psel_low", bus.PSEL, 1'b0);
        chk("tmo_latency", c0 - a0, 2 + TMO);
        issue(1'b0, 32'h30, '0, 1, a0);
        drain();

        for (int i = 0; i < 40; i++) begin
            int gap;
            logic w;
            logic [AW-1:0] ad;
            w   = 1'($urandom_range(0, 1));
            ad  = AW'($urandom_range(0, 15) * 4);
            issue(w, ad, $urandom, ($urandom_range(0, 7) == 0) ? STUCK : $urandom_range(0, 3), a0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge PCLK);
        end
        drain();

        // Reset during ACCESS with a second command buffered.
        issue(1'b1, 32'h3C, 32'h55AA55AA, STUCK, a0);
        issue(1'b0, 32'h10, '0, 0, a1);
        #2;
        chk("pre_reset_access", {bus.PSEL, bus.PENABLE, bus.busy}, 3'b111);
        PRESETn = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        exp_q.delete();
        waits_q.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_reset_ready", bus.req_ready, 1'b1);
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (bus.PSEL || bus.busy) highs++;
        end
        chk("no_stale_transfer", highs, 0);

        issue(1'b0, 32'h04, '0, 2, a0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
